// File: rtl/tile_cfg_frame_loader_if.sv
// Config stream, status and bl/wl bundle for tile_cfg_frame_loader.
// The cfg_chk signal exists only when CFG_CHECKSUM_EN is defined.
interface tile_cfg_frame_loader_if #(
    parameter int unsigned CFG_BITS = 158,
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned CW       = 5
) ();
    logic                cfg_start;
    logic                cfg_abort;
    logic [IN_WIDTH-1:0] cfg_data;
    logic                cfg_valid;
`ifdef CFG_CHECKSUM_EN
    logic [IN_WIDTH-1:0] cfg_chk;
`endif
    logic                cfg_ready;
    logic                cfg_busy;
    logic                cfg_done;
    logic                cfg_err;
    logic [CW-1:0]       word_count;
    logic [0:CFG_BITS-1] bl;
    logic [0:CFG_BITS-1] wl;

    modport master (
        output cfg_start, cfg_abort, cfg_data, cfg_valid,
`ifdef CFG_CHECKSUM_EN
        output cfg_chk,
`endif
        input  cfg_ready, cfg_busy, cfg_done, cfg_err, word_count, bl, wl
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_data, cfg_valid,
`ifdef CFG_CHECKSUM_EN
        input  cfg_chk,
`endif
        output cfg_ready, cfg_busy, cfg_done, cfg_err, word_count, bl, wl
    );
endinterface

// File: rtl/tile_cfg_frame_loader.sv
// Streams IN_WIDTH-bit words onto a flat bl/wl tile bus, one group per word:
// bl setup, WL_PULSE-cycle wl pulse, bl hold. Define CFG_CHECKSUM_EN for the XOR check.
module tile_cfg_frame_loader #(
    parameter int unsigned CFG_BITS = 158,
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned WL_PULSE = 2
) (
    input logic                   prog_clk,
    input logic                   pReset,
    tile_cfg_frame_loader_if.slave bus
);
    localparam int unsigned NUM_WORDS = (CFG_BITS + IN_WIDTH - 1) / IN_WIDTH;
    localparam int unsigned CW        = $clog2(NUM_WORDS + 1);
    localparam int unsigned PW        = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    typedef enum logic [2:0] {
        StIdle, StWait, StSetup, StPulse, StHold, StDone
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       pulse_q, pulse_d;
    logic [IN_WIDTH-1:0] word_q, word_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef CFG_CHECKSUM_EN
    logic [IN_WIDTH-1:0] chk_q, chk_d;
    logic [IN_WIDTH-1:0] xor_q, xor_d;
`endif
    logic                busy, bl_en, wl_en;
    logic [0:CFG_BITS-1] bl_vec, wl_vec;

    always_comb begin
        busy  = state_q inside {StWait, StSetup, StPulse, StHold};
        bl_en = state_q inside {StSetup, StPulse, StHold};
        wl_en = (state_q == StPulse);
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = pulse_q;
        word_d  = word_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef CFG_CHECKSUM_EN
        chk_d   = chk_q;
        xor_d   = xor_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.cfg_start) begin
                    state_d = StWait;
                    count_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef CFG_CHECKSUM_EN
                    chk_d   = bus.cfg_chk;
                    xor_d   = '0;
`endif
                end else if (bus.cfg_valid) begin
                    err_d = 1'b1;
                end
            end
            StWait: begin
                if (bus.cfg_valid) begin
                    word_d  = bus.cfg_data;
                    state_d = StSetup;
`ifdef CFG_CHECKSUM_EN
                    xor_d   = xor_q ^ bus.cfg_data;
`endif
                end
            end
            StSetup: begin
                pulse_d = '0;
                state_d = StPulse;
            end
            StPulse: begin
                if (pulse_q == PW'(WL_PULSE - 1)) state_d = StHold;
                else                              pulse_d = pulse_q + 1'b1;
            end
            StHold: begin
                count_d = count_q + 1'b1;
                state_d = (count_q == CW'(NUM_WORDS - 1)) ? StDone : StWait;
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (bus.cfg_valid) err_d = 1'b1;
`ifdef CFG_CHECKSUM_EN
                if (xor_q != chk_q) err_d = 1'b1;
`endif
            end
            default: state_d = StIdle;
        endcase
        // Abort beats every other transition, including the final HOLD -> DONE.
        if (busy && bus.cfg_abort) begin
            state_d = StIdle;
            count_d = count_q;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q <= StIdle;
            count_q <= '0;
            pulse_q <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            chk_q   <= '0;
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pulse_q <= pulse_d;
            word_q  <= word_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef CFG_CHECKSUM_EN
            chk_q   <= chk_d;
            xor_q   <= xor_d;
`endif
        end
    end

    // Bits past CFG_BITS in the last word have no line to land on and are simply dropped.
    for (genvar i = 0; i < CFG_BITS; i++) begin : g_bit
        localparam int unsigned Grp = i / IN_WIDTH;
        localparam int unsigned Bit = i % IN_WIDTH;
        assign bl_vec[i] = bl_en && (count_q == CW'(Grp)) && word_q[Bit];
        assign wl_vec[i] = wl_en && (count_q == CW'(Grp));
    end

    always_comb begin
        bus.cfg_ready  = (state_q == StWait);
        bus.cfg_busy   = busy;
        bus.cfg_done   = done_q;
        bus.cfg_err    = err_q;
        bus.word_count = count_q;
        bus.bl         = bl_vec;
        bus.wl         = wl_vec;
    end
endmodule

// File: tb/tb_tile_cfg_frame_loader.sv
// Randomized self-checking bench for tile_cfg_frame_loader; the reference is the
// packed bit image, per-bit pulse counts and the 5+gap cycles-per-word timing rule.
module tb_tile_cfg_frame_loader;
    localparam int unsigned CFG_BITS = 158;
    localparam int unsigned IN_WIDTH = 8;
    localparam int unsigned WL_PULSE = 2;
    localparam int unsigned NW       = (CFG_BITS + IN_WIDTH - 1) / IN_WIDTH;
    localparam int unsigned CW       = $clog2(NW + 1);

    logic clk, rst;
    int   n_checks, n_fail;

    logic [IN_WIDTH-1:0] words [NW];
    int                  gaps  [NW];
    int                  gap_bad;
`ifdef CFG_CHECKSUM_EN
    logic [IN_WIDTH-1:0] chk_flip;
`endif

    // Monitor state
    int                  wl_cnt [CFG_BITS];
    logic [0:CFG_BITS-1] bl_seen, bl_prev, wl_prev;
    int                  glitch_cnt, span_err;

    tile_cfg_frame_loader_if #(.CFG_BITS(CFG_BITS), .IN_WIDTH(IN_WIDTH), .CW(CW)) bus ();

    tile_cfg_frame_loader #(
        .CFG_BITS(CFG_BITS),
        .IN_WIDTH(IN_WIDTH),
        .WL_PULSE(WL_PULSE)
    ) dut (
        .prog_clk(clk),
        .pReset  (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        int g0;
        bit any;
        if (bus.wl != '0 && bus.bl != bl_prev) glitch_cnt++;
        if (wl_prev != '0 && bus.bl != bl_prev) glitch_cnt++;
        any = 1'b0;
        g0  = 0;
        for (int i = 0; i < CFG_BITS; i++) begin
            if (bus.wl[i]) begin
                wl_cnt[i]++;
                bl_seen[i] = bus.bl[i];
            end
            if (bus.wl[i] || bus.bl[i]) begin
                if (!any) begin
                    any = 1'b1;
                    g0  = i / IN_WIDTH;
                end else if (i / IN_WIDTH != g0) begin
                    span_err++;
                end
            end
        end
        bl_prev = bus.bl;
        wl_prev = bus.wl;
    end

    // Starts a load and hands over words 0..n-1, honouring gaps[]; returns after the last handshake.
    task automatic feed(input int n, output bit ok, output time t_hs0);
        bit rdy;
        ok    = 1'b1;
        t_hs0 = 0;
        @(posedge clk); #1;
        for (int i = 0; i < CFG_BITS; i++) wl_cnt[i] = 0;
        bl_seen    = '0;
        glitch_cnt = 0;
        span_err   = 0;
        gap_bad    = 0;
`ifdef CFG_CHECKSUM_EN
        bus.cfg_chk = chk_flip;
        for (int k = 0; k < NW; k++) bus.cfg_chk = bus.cfg_chk ^ words[k];
`endif
        bus.cfg_start = 1'b1;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        for (int k = 0; k < n && ok; k++) begin
            rdy = 1'b0;
            for (int c = 0; c < 16 && !rdy; c++) begin
                @(negedge clk);
                rdy = bus.cfg_ready;
            end
            if (!rdy) begin
                ok = 1'b0;
            end else begin
                for (int g = 0; g < gaps[k]; g++) begin
                    @(negedge clk);
                    if (bus.cfg_ready !== 1'b1 || bus.wl != '0 || bus.bl != '0) gap_bad++;
                    bus.cfg_start = 1'b1;  // must be ignored while busy
                end
                bus.cfg_start = 1'b0;
                bus.cfg_data  = words[k];
                bus.cfg_valid = 1'b1;
                if (k == 0) t_hs0 = $time + 5;
                @(posedge clk); #1;
                bus.cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic do_load(input string name);
        bit                  ok, seen, exp_err;
        time                 t_hs0, t_done;
        int                  exp_cyc;
        logic [0:CFG_BITS-1] exp_bl, wl_ok, all_ones;
        exp_cyc = 5 * NW;
        for (int k = 1; k < NW; k++) exp_cyc += gaps[k];
        for (int i = 0; i < CFG_BITS; i++) begin
            exp_bl[i]   = words[i / IN_WIDTH][i % IN_WIDTH];
            all_ones[i] = 1'b1;
        end
`ifdef CFG_CHECKSUM_EN
        exp_err = (chk_flip != '0);
`else
        exp_err = 1'b0;
`endif
        feed(NW, ok, t_hs0);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s feed: cfg_ready never rose, got %0d want 1", name, ok);
        end
        seen   = 1'b0;
        t_done = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.cfg_done === 1'b1) begin
                seen   = 1'b1;
                t_done = $time - 5;
            end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL %s done_seen: got %0d want 1", name, seen);
        end
        n_checks++;
        if (t_done - t_hs0 !== time'(exp_cyc * 10)) begin
            n_fail++;
            $display("FAIL %s done_latency: got %0d cycles want %0d", name,
                     (t_done - t_hs0) / 10, exp_cyc);
        end
        n_checks++;
        if (bus.word_count !== CW'(NW)) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d want %0d", name, bus.word_count, NW);
        end
        n_checks++;
        if (bus.cfg_err !== exp_err) begin
            n_fail++;
            $display("FAIL %s cfg_err: got %0d want %0d", name, bus.cfg_err, exp_err);
        end
        n_checks++;
        if (bus.cfg_busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after_done: busy %0d ready %0d want 0 0", name,
                     bus.cfg_busy, bus.cfg_ready);
        end
        for (int i = 0; i < CFG_BITS; i++) wl_ok[i] = (wl_cnt[i] == WL_PULSE);
        n_checks++;
        if (bl_seen !== exp_bl) begin
            n_fail++;
            $display("FAIL %s bl_image: got %h want %h", name, bl_seen, exp_bl);
        end
        n_checks++;
        if (wl_ok !== all_ones) begin
            n_fail++;
            $display("FAIL %s wl_pulse_len: bits ok %h want %h", name, wl_ok, all_ones);
        end
        n_checks++;
        if (glitch_cnt !== 0) begin
            n_fail++;
            $display("FAIL %s bl_wl_overlap: got %0d events want 0", name, glitch_cnt);
        end
        n_checks++;
        if (span_err !== 0) begin
            n_fail++;
            $display("FAIL %s group_span: got %0d events want 0", name, span_err);
        end
        n_checks++;
        if (gap_bad !== 0) begin
            n_fail++;
            $display("FAIL %s wait_gap: got %0d bad cycles want 0", name, gap_bad);
        end
    endtask

    task automatic wait_wl(input bit level, output bit hit);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge clk);
            hit = ((bus.wl != '0) == level);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks += 7;
        if (bus.bl !== '0) begin n_fail++; $display("FAIL reset bl: got %h want 0", bus.bl); end
        if (bus.wl !== '0) begin n_fail++; $display("FAIL reset wl: got %h want 0", bus.wl); end
        if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %0d want 0", bus.cfg_busy); end
        if (bus.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %0d want 0", bus.cfg_ready); end
        if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %0d want 0", bus.cfg_done); end
        if (bus.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %0d want 0", bus.cfg_err); end
        if (bus.word_count !== '0) begin n_fail++; $display("FAIL reset word_count: got %0d want 0", bus.word_count); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_load;
        for (int k = 0; k < NW; k++) begin
            words[k] = IN_WIDTH'(k + 1);
            gaps[k]  = 0;
        end
        do_load("full_load");
    endtask

    task automatic test_stray_valid;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b1;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL stray_valid err: got %0d want 1", bus.cfg_err); end
        if (bus.cfg_busy !== 1'b0 || bus.cfg_done !== 1'b1) begin
            n_fail++;
            $display("FAIL stray_valid state: busy %0d done %0d want 0 1", bus.cfg_busy, bus.cfg_done);
        end
    endtask

    task automatic test_partial_last;
        for (int k = 0; k < NW; k++) begin
            words[k] = IN_WIDTH'($urandom);
            gaps[k]  = 0;
        end
        words[NW-1] = 8'hFF;
        do_load("partial_last");
        n_checks++;
        if (bl_seen[152:157] !== 6'b111111 || wl_cnt[157] !== WL_PULSE) begin
            n_fail++;
            $display("FAIL partial_last top_bits: bl %b wl_cnt %0d want 111111 %0d",
                     bl_seen[152:157], wl_cnt[157], WL_PULSE);
        end
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < NW; k++) begin
            words[k] = IN_WIDTH'($urandom);
            gaps[k]  = 0;
        end
        gaps[5] = 7;
        do_load("backpressure");
    endtask

    task automatic test_random_loads;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NW; k++) begin
                words[k] = IN_WIDTH'($urandom);
                gaps[k]  = (k == 0) ? 0 : int'($urandom_range(0, 3));
            end
            do_load($sformatf("random_%0d", r));
        end
    endtask

    task automatic test_abort;
        bit  ok, hit;
        time t;
        for (int k = 0; k < NW; k++) begin
            words[k] = IN_WIDTH'($urandom);
            gaps[k]  = 0;
        end
        feed(4, ok, t);
        wait_wl(1'b1, hit);
        n_checks++;
        if (!(ok && hit)) begin n_fail++; $display("FAIL abort reach_pulse: got %0d want 1", ok && hit); end
        bus.cfg_abort = 1'b1;
        @(posedge clk); #1;
        bus.cfg_abort = 1'b0;
        @(negedge clk);
        n_checks += 5;
        if (bus.wl !== '0 || bus.bl !== '0) begin n_fail++; $display("FAIL abort lines: bl %h wl %h want 0", bus.bl, bus.wl); end
        if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL abort err: got %0d want 1", bus.cfg_err); end
        if (bus.cfg_busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %0d want 0", bus.cfg_busy); end
        if (bus.word_count !== CW'(3)) begin n_fail++; $display("FAIL abort word_count: got %0d want 3", bus.word_count); end
        if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL abort done: got %0d want 0", bus.cfg_done); end
        @(posedge clk); #1;
        bus.cfg_start = 1'b1;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (bus.cfg_err !== 1'b0 || bus.word_count !== '0) begin
            n_fail++;
            $display("FAIL abort restart_clear: err %0d count %0d want 0 0", bus.cfg_err, bus.word_count);
        end
        if (bus.cfg_busy !== 1'b1 || bus.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort restart_wait: busy %0d ready %0d want 1 1", bus.cfg_busy, bus.cfg_ready);
        end
        bus.cfg_abort = 1'b1;
        @(posedge clk); #1;
        bus.cfg_abort = 1'b0;
    endtask

    task automatic test_abort_last_hold;
        bit  ok, hit1, hit2;
        time t;
        for (int k = 0; k < NW; k++) begin
            words[k] = IN_WIDTH'($urandom);
            gaps[k]  = 0;
        end
        feed(NW, ok, t);
        wait_wl(1'b1, hit1);
        wait_wl(1'b0, hit2);
        n_checks++;
        if (!(ok && hit1 && hit2 && bus.cfg_busy === 1'b1)) begin
            n_fail++;
            $display("FAIL abort_hold reach_hold: got %0d want 1", ok && hit1 && hit2);
        end
        bus.cfg_abort = 1'b1;
        @(posedge clk); #1;
        bus.cfg_abort = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 3;
        if (bus.cfg_done !== 1'b0) begin n_fail++; $display("FAIL abort_hold done: got %0d want 0", bus.cfg_done); end
        if (bus.cfg_err !== 1'b1) begin n_fail++; $display("FAIL abort_hold err: got %0d want 1", bus.cfg_err); end
        if (bus.word_count !== CW'(NW - 1)) begin
            n_fail++;
            $display("FAIL abort_hold word_count: got %0d want %0d", bus.word_count, NW - 1);
        end
    endtask

    task automatic test_reset_mid_pulse;
        bit  ok, hit;
        time t;
        feed(2, ok, t);
        wait_wl(1'b1, hit);
        n_checks++;
        if (!(ok && hit)) begin n_fail++; $display("FAIL reset_mid reach_pulse: got %0d want 1", ok && hit); end
        rst = 1'b1;
        @(negedge clk);
        n_checks += 4;
        if (bus.bl !== '0 || bus.wl !== '0) begin n_fail++; $display("FAIL reset_mid lines: bl %h wl %h want 0", bus.bl, bus.wl); end
        if (bus.cfg_busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid handshake: busy %0d ready %0d want 0 0", bus.cfg_busy, bus.cfg_ready);
        end
        if (bus.cfg_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid flags: done %0d err %0d want 0 0", bus.cfg_done, bus.cfg_err);
        end
        if (bus.word_count !== '0) begin n_fail++; $display("FAIL reset_mid word_count: got %0d want 0", bus.word_count); end
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef CFG_CHECKSUM_EN
    task automatic test_checksum;
        for (int k = 0; k < NW; k++) begin
            words[k] = IN_WIDTH'(k + 1);
            gaps[k]  = 0;
        end
        chk_flip = 8'h00;
        do_load("checksum_good");
        chk_flip = 8'h01;
        do_load("checksum_bad");
        chk_flip = 8'h00;
    endtask
`endif

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        glitch_cnt    = 0;
        span_err      = 0;
        gap_bad       = 0;
        bl_prev       = '0;
        wl_prev       = '0;
        bl_seen       = '0;
        bus.cfg_start = 1'b0;
        bus.cfg_abort = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_valid = 1'b0;
`ifdef CFG_CHECKSUM_EN
        chk_flip      = '0;
        bus.cfg_chk   = '0;
`endif
        test_reset();
        test_full_load();
        test_stray_valid();
        test_partial_last();
        test_backpressure();
        test_random_loads();
        test_abort();
        test_abort_last_hold();
        test_reset_mid_pulse();
`ifdef CFG_CHECKSUM_EN
        test_checksum();
`endif
        test_full_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
